// File: rtl/psum_pass_ctrl_pkg.sv
// rtl/psum_pass_ctrl_pkg.sv - shared state encoding and width defaults for the partial-sum pass controller
package psum_pass_ctrl_pkg;

    localparam int PIX_W_DEF  = 15;
    localparam int PASS_W_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_REFRESH  = 3'd1,
        ST_RUN      = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_PASS_END = 3'd4,
        ST_DONE     = 3'd5
    } state_e;

endpackage

// File: rtl/psum_sat_counter.sv
// rtl/psum_sat_counter.sv - clearable up-counter that holds at all-ones instead of wrapping
module psum_sat_counter #(
    parameter int W = 8
) (
    input  logic         system_clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/psum_pass_ctrl.sv
// rtl/psum_pass_ctrl.sv - sequences input-channel passes over the output buffer (overwrite, then accumulate)
// Optional write-overflow detection enabled by defining PSUM_CTRL_OVERFLOW_CHECK_EN.
module psum_pass_ctrl
    import psum_pass_ctrl_pkg::*;
#(
    parameter int PIX_W  = PIX_W_DEF,
    parameter int PASS_W = PASS_W_DEF
) (
    input  logic              system_clk,
    input  logic              rst_n,
    input  logic              cfg_start,
    input  logic [PASS_W-1:0] cfg_pass_num,
    input  logic [PIX_W:0]    cfg_pixel_num,
    input  logic              cfg_abort,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic              feature_valid,
    output logic              refresh_req,
    output logic              adder_pulse,
    output logic              accumulate_en,
    output logic              last_pass,
    output logic              pass_done,
    output logic              layer_done,
    output logic              busy,
    output logic              err_overflow
);

    state_e            state;
    state_e            state_nxt;
    logic [PASS_W-1:0] pass_num;
    logic [PASS_W-1:0] pass_num_nxt;
    logic [PASS_W-1:0] pass_idx;
    logic [PASS_W-1:0] pass_idx_nxt;
    logic [PIX_W:0]    pix_num;
    logic [PIX_W:0]    issue_cnt;
    logic [PIX_W:0]    wr_cnt;
    logic [PIX_W+1:0]  wr_sum;
    logic              start_hit;
    logic              abort_hit;
    logic              fire;
    logic              last_fire;
    logic              wr_reach;
    logic              is_last;
    logic              pass_inc;

    assign abort_hit    = cfg_abort && (state != ST_IDLE);
    assign start_hit    = cfg_start && !cfg_abort && (state == ST_IDLE);
    assign fire         = issue_valid && issue_ready;
    assign adder_pulse  = fire && accumulate_en;
    assign last_fire    = fire && (({1'b0, issue_cnt} + (PIX_W+2)'(1)) == {1'b0, pix_num});
    // Count the write landing this cycle so DRAIN exits without an extra idle cycle.
    assign wr_sum       = {1'b0, wr_cnt} + (PIX_W+2)'(feature_valid);
    assign wr_reach     = wr_sum >= {1'b0, pix_num};
    assign is_last      = (pass_idx == (pass_num - PASS_W'(1)));
    assign pass_inc     = (state == ST_PASS_END) && !is_last && !abort_hit;
    assign pass_num_nxt = !start_hit ? pass_num :
                          (cfg_pass_num == '0) ? PASS_W'(1) : cfg_pass_num;
    assign pass_idx_nxt = start_hit ? '0 : (pass_inc ? pass_idx + PASS_W'(1) : pass_idx);

    psum_sat_counter #(.W(PIX_W+1)) u_issue_cnt (
        .system_clk (system_clk),
        .rst_n      (rst_n),
        .clr        (state == ST_REFRESH),
        .inc        (fire && (state == ST_RUN)),
        .cnt        (issue_cnt)
    );

    psum_sat_counter #(.W(PIX_W+1)) u_wr_cnt (
        .system_clk (system_clk),
        .rst_n      (rst_n),
        .clr        (state == ST_REFRESH),
        .inc        (feature_valid && ((state == ST_RUN) || (state == ST_DRAIN))),
        .cnt        (wr_cnt)
    );

    psum_sat_counter #(.W(PASS_W)) u_pass_idx (
        .system_clk (system_clk),
        .rst_n      (rst_n),
        .clr        (start_hit),
        .inc        (pass_inc),
        .cnt        (pass_idx)
    );

    always_comb begin
        state_nxt = state;
        if (abort_hit) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:     if (start_hit) state_nxt = ST_REFRESH;
                ST_REFRESH:  state_nxt = ST_RUN;
                ST_RUN: begin
                    if (pix_num == '0)  state_nxt = ST_PASS_END;
                    else if (last_fire) state_nxt = ST_DRAIN;
                end
                ST_DRAIN:    if (wr_reach) state_nxt = ST_PASS_END;
                ST_PASS_END: state_nxt = is_last ? ST_DONE : ST_REFRESH;
                ST_DONE:     state_nxt = ST_IDLE;
                default:     state_nxt = ST_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so they line up with the state they describe.
    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            pass_num      <= '0;
            pix_num       <= '0;
            issue_ready   <= 1'b0;
            refresh_req   <= 1'b0;
            accumulate_en <= 1'b0;
            last_pass     <= 1'b0;
            pass_done     <= 1'b0;
            layer_done    <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state    <= state_nxt;
            pass_num <= pass_num_nxt;
            if (start_hit) begin
                pix_num <= cfg_pixel_num;
            end
            issue_ready   <= (state_nxt == ST_RUN) && (pix_num != '0);
            refresh_req   <= (state_nxt == ST_REFRESH) || abort_hit;
            accumulate_en <= (state_nxt != ST_IDLE) && (pass_idx_nxt != '0);
            last_pass     <= (state_nxt != ST_IDLE) && (pass_idx_nxt == (pass_num_nxt - PASS_W'(1)));
            pass_done     <= (state_nxt == ST_PASS_END);
            layer_done    <= (state_nxt == ST_DONE);
            busy          <= (state_nxt != ST_IDLE);
        end
    end

`ifdef PSUM_CTRL_OVERFLOW_CHECK_EN
    logic ovf_hit;

    assign ovf_hit = feature_valid &&
                     ((state == ST_IDLE) || (state == ST_REFRESH) ||
                      (state == ST_PASS_END) || (state == ST_DONE) ||
                      (wr_cnt == pix_num));

    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            err_overflow <= 1'b0;
        end else if (start_hit) begin
            err_overflow <= 1'b0;
        end else if (ovf_hit) begin
            err_overflow <= 1'b1;
        end
    end
`else
    assign err_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_psum_pass_ctrl.sv
// tb/tb_psum_pass_ctrl.sv - directed self-checking bench for psum_pass_ctrl
module tb_psum_pass_ctrl;

    localparam int PIX_W  = 15;
    localparam int PASS_W = 8;
`ifdef PSUM_CTRL_OVERFLOW_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic              system_clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cfg_start = 1'b0;
    logic [PASS_W-1:0] cfg_pass_num = '0;
    logic [PIX_W:0]    cfg_pixel_num = '0;
    logic              cfg_abort = 1'b0;
    logic              issue_valid = 1'b0;
    logic              issue_ready;
    logic              feature_valid;
    logic              refresh_req;
    logic              adder_pulse;
    logic              accumulate_en;
    logic              last_pass;
    logic              pass_done;
    logic              layer_done;
    logic              busy;
    logic              err_overflow;
    logic [8:0]        outs;

    logic       fv_auto = 1'b0;
    logic       fv_force = 1'b0;
    logic       fv_q = 1'b0;
    logic [1:0] fpipe = 2'b00;

    int n_cmp = 0;
    int n_bad = 0;
    int n_refresh, n_pass_done, n_layer_done, n_fire, n_acc;
    int n_adder[4];
    int n_fire_p[4];
    int n_last[4];

    always #5 system_clk = ~system_clk;

    assign feature_valid = fv_q | fv_force;
    assign outs = {issue_ready, refresh_req, adder_pulse, accumulate_en, last_pass,
                   pass_done, layer_done, busy, err_overflow};

    psum_pass_ctrl #(.PIX_W(PIX_W), .PASS_W(PASS_W)) dut (
        .system_clk    (system_clk),
        .rst_n         (rst_n),
        .cfg_start     (cfg_start),
        .cfg_pass_num  (cfg_pass_num),
        .cfg_pixel_num (cfg_pixel_num),
        .cfg_abort     (cfg_abort),
        .issue_valid   (issue_valid),
        .issue_ready   (issue_ready),
        .feature_valid (feature_valid),
        .refresh_req   (refresh_req),
        .adder_pulse   (adder_pulse),
        .accumulate_en (accumulate_en),
        .last_pass     (last_pass),
        .pass_done     (pass_done),
        .layer_done    (layer_done),
        .busy          (busy),
        .err_overflow  (err_overflow)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Event tally sampled mid-cycle; feature_valid follows each fire by two cycles.
    always begin : monitor
        int pidx;
        @(negedge system_clk);
        pidx = (n_pass_done > 3) ? 3 : n_pass_done;
        if (refresh_req) n_refresh++;
        if (adder_pulse) n_adder[pidx]++;
        if (issue_valid && issue_ready) begin
            n_fire++;
            n_fire_p[pidx]++;
        end
        if (accumulate_en) n_acc++;
        if (last_pass) n_last[pidx]++;
        if (pass_done) n_pass_done++;
        if (layer_done) n_layer_done++;
        fpipe = {fpipe[0], issue_valid & issue_ready & fv_auto};
        @(posedge system_clk);
        #1;
        fv_q = fpipe[1];
    end

    task automatic clear_stats();
        n_refresh = 0; n_pass_done = 0; n_layer_done = 0; n_fire = 0; n_acc = 0;
        for (int i = 0; i < 4; i++) begin
            n_adder[i] = 0; n_fire_p[i] = 0; n_last[i] = 0;
        end
    endtask

    task automatic start_layer(input int pass_n, input int pix_n);
        @(posedge system_clk); #1;
        cfg_start     = 1'b1;
        cfg_pass_num  = PASS_W'(pass_n);
        cfg_pixel_num = (PIX_W+1)'(pix_n);
        @(posedge system_clk); #1;
        cfg_start = 1'b0;
    endtask

    task automatic wait_layer(input string tag, input int budget);
        int k = 0;
        while (n_layer_done < 1 && k < budget) begin
            @(negedge system_clk); #1;
            k++;
        end
        check_eq(tag, (n_layer_done >= 1), 1);
    endtask

    task automatic go_idle();
        @(posedge system_clk); #1;
        issue_valid = 1'b0;
        fv_auto     = 1'b0;
        repeat (4) @(posedge system_clk);
        #1;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got timeout expected summary");
        $fatal(1);
    end

    initial begin : main
        int k;
        clear_stats();
        repeat (3) @(posedge system_clk);
        #1;
        check_eq("reset_outs", outs, 0);
        rst_n = 1'b1;
        @(negedge system_clk);
        check_eq("idle_outs", outs, 0);

        // Three passes of four pixels
        clear_stats();
        issue_valid = 1'b1;
        fv_auto     = 1'b1;
        start_layer(3, 4);
        wait_layer("s1_layer_wait", 200);
        check_eq("s1_refresh", n_refresh, 3);
        check_eq("s1_adder_p0", n_adder[0], 0);
        check_eq("s1_adder_p1", n_adder[1], 4);
        check_eq("s1_adder_p2", n_adder[2], 4);
        check_eq("s1_fires", n_fire, 12);
        check_eq("s1_pass_done", n_pass_done, 3);
        check_eq("s1_last_p0", n_last[0], 0);
        check_eq("s1_last_p1", n_last[1], 0);
        check_eq("s1_last_p2", (n_last[2] > 0), 1);
        go_idle();
        check_eq("s1_layer_done", n_layer_done, 1);
        check_eq("s1_idle_outs", outs, 0);

        // pass_num=0 behaves as one pass
        clear_stats();
        issue_valid = 1'b1;
        fv_auto     = 1'b1;
        start_layer(0, 2);
        wait_layer("s2_layer_wait", 100);
        check_eq("s2_pass_done", n_pass_done, 1);
        check_eq("s2_fires", n_fire, 2);
        check_eq("s2_acc_cycles", n_acc, 0);
        check_eq("s2_refresh", n_refresh, 1);
        go_idle();

        // pixel_num=0: passes complete with no fires
        clear_stats();
        issue_valid = 1'b1;
        fv_auto     = 1'b1;
        start_layer(2, 0);
        wait_layer("s3_layer_wait", 100);
        check_eq("s3_pass_done", n_pass_done, 2);
        check_eq("s3_fires", n_fire, 0);
        check_eq("s3_refresh", n_refresh, 2);
        go_idle();
        check_eq("s3_layer_done", n_layer_done, 1);

        // Abort during DRAIN of pass 1
        clear_stats();
        issue_valid = 1'b1;
        fv_auto     = 1'b1;
        start_layer(3, 4);
        k = 0;
        while (!(n_pass_done == 1 && n_fire_p[1] == 4) && k < 200) begin
            @(negedge system_clk); #1;
            k++;
        end
        check_eq("s4_reach_drain", (n_fire_p[1] == 4), 1);
        check_eq("s4_refresh_pre", n_refresh, 2);
        @(posedge system_clk); #1;
        cfg_abort   = 1'b1;
        issue_valid = 1'b0;
        @(posedge system_clk); #1;
        cfg_abort = 1'b0;
        fv_auto   = 1'b0;
        check_eq("s4_busy", busy, 0);
        check_eq("s4_refresh_now", refresh_req, 1);
        check_eq("s4_issue_ready", issue_ready, 0);
        repeat (6) @(negedge system_clk);
        #1;
        check_eq("s4_refresh_total", n_refresh, 3);
        check_eq("s4_pass_done", n_pass_done, 1);
        check_eq("s4_layer_done", n_layer_done, 0);
        go_idle();

        // Asynchronous reset in the middle of RUN
        clear_stats();
        issue_valid = 1'b1;
        fv_auto     = 1'b1;
        start_layer(2, 4);
        k = 0;
        while (n_fire < 2 && k < 50) begin
            @(negedge system_clk); #1;
            k++;
        end
        check_eq("s5_in_run", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("s5_rst_outs", outs, 0);
        issue_valid = 1'b0;
        fv_auto     = 1'b0;
        repeat (3) @(posedge system_clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(negedge system_clk);
        #1;
        check_eq("s5_no_pass_done", n_pass_done, 0);
        check_eq("s5_no_layer_done", n_layer_done, 0);
        check_eq("s5_post_rst_outs", outs, 0);
        clear_stats();
        issue_valid = 1'b1;
        fv_auto     = 1'b1;
        start_layer(1, 3);
        wait_layer("s5_layer_wait", 100);
        check_eq("s5_pass_done", n_pass_done, 1);
        check_eq("s5_fires", n_fire, 3);
        check_eq("s5_adder", n_adder[0], 0);
        go_idle();

        // Write overflow: a third feature_valid after a two-pixel layer
        clear_stats();
        issue_valid = 1'b1;
        fv_auto     = 1'b1;
        start_layer(1, 2);
        wait_layer("s6_layer_wait", 100);
        check_eq("s6_err_clean", err_overflow, 0);
        go_idle();
        fv_force = 1'b1;
        @(posedge system_clk); #1;
        fv_force = 1'b0;
        @(negedge system_clk);
        check_eq("s6_err_set", err_overflow, EXP_ERR);
        repeat (3) @(negedge system_clk);
        check_eq("s6_err_sticky", err_overflow, EXP_ERR);
        clear_stats();
        issue_valid = 1'b1;
        fv_auto     = 1'b1;
        start_layer(1, 1);
        check_eq("s6_err_clr", err_overflow, 0);
        wait_layer("s6b_layer_wait", 100);
        check_eq("s6b_err", err_overflow, 0);
        go_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
